// File: rtl/load_store_unit.sv
// RV32I load/store stage: byte-lane stores and sign/zero-extended loads against an
// internal synchronous-read RAM, with fault detection for illegal, misaligned or out-of-range accesses.
module load_store_unit #(
  parameter int MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        busy
);

  localparam int AW    = $clog2(MEM_BYTES);
  localparam int WORDS = MEM_BYTES / 4;
  localparam int IW    = (AW > 2) ? AW - 2 : 1;

  typedef enum logic [1:0] {IDLE, READ, RESP} state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [31:0] word_q;
  logic [31:0] mem [WORDS];

  logic          accept, req_fault, illegal, misaligned, out_of_range, wr_en;
  logic [3:0]    be;
  logic [31:0]   wlane, load_ext;
  logic [7:0]    sel_b;
  logic [15:0]   sel_h;
  logic [IW-1:0] word_idx;

  assign word_idx = IW'(req_addr >> 2);
  assign accept   = req_valid && (state_q == IDLE) && !reset;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    illegal      = 1'b0;
    misaligned   = 1'b0;
    be           = 4'b1111;
    wlane        = req_wdata;
    if (req_we) illegal = (req_funct3 != 3'b000) && (req_funct3 != 3'b001) && (req_funct3 != 3'b010);
    else        illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    case (req_funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << req_addr[1:0];
        wlane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = req_addr[0];
        be         = req_addr[1] ? 4'b1100 : 4'b0011;
        wlane      = {2{req_wdata[15:0]}};
      end
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    // Full 32-bit compare so high address bits never alias into the RAM.
    out_of_range = (req_addr >= 32'(MEM_BYTES));
    req_fault    = illegal || misaligned || out_of_range;
    wr_en        = accept && req_we && !req_fault;
  end

  // NOTE: the RAM array has no reset; its contents survive reset by design.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
    if (accept && !req_we && !req_fault) word_q <= mem[word_idx];
  end

  always_comb begin
    sel_b = word_q[{off_q, 3'b000} +: 8];
    sel_h = off_q[1] ? word_q[31:16] : word_q[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{sel_b[7]}}, sel_b};
      3'b001:  load_ext = {{16{sel_h[15]}}, sel_h};
      3'b100:  load_ext = {24'h0, sel_b};
      3'b101:  load_ext = {16'h0, sel_h};
      default: load_ext = word_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_fault || req_we) begin
            rdata_d = 32'h0;
            fault_d = req_fault;
            state_d = RESP;
          end else begin
            off_d   = req_addr[1:0];
            f3_d    = req_funct3;
            state_d = READ;
          end
        end
      end
      READ: begin
        rdata_d = load_ext;
        fault_d = 1'b0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = !req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: loads/stores, extension, faults,
// back-to-back throughput and reset during an in-flight load.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault, busy;
  logic [31:0] resp_rdata;

  int n_checks = 0;
  int n_fails  = 0;

  load_store_unit #(.MEM_BYTES(4096)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request from IDLE; verifies response latency, data, fault and post-pulse hold.
  task automatic do_op(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_flt, input int lat);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    @(negedge clk);
    check({tag, " ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 5 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        n   = i;
      end
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " rdata"}, resp_rdata, exp_rd);
    check({tag, " fault"}, {31'h0, resp_fault}, {31'h0, exp_flt});
    @(negedge clk);
    check({tag, " pulse end"}, {31'h0, resp_valid}, 32'h0);
    check({tag, " rdata hold"}, resp_rdata, exp_rd);
    check({tag, " fault hold"}, {31'h0, resp_fault}, {31'h0, exp_flt});
  endtask

  // Back-to-back op table: alternating SW/LW with req_valid held high.
  logic        bb_we [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] bb_ad [6] = '{32'h20, 32'h20, 32'h24, 32'h24, 32'h20, 32'h20};
  logic [31:0] bb_wd [6] = '{32'h11112222, 32'h0, 32'h33334444, 32'h0, 32'h55556666, 32'h0};
  logic [31:0] bb_ex [6] = '{32'h0, 32'h11112222, 32'h0, 32'h33334444, 32'h0, 32'h55556666};

  initial begin
    int acc_cyc [6];
    int nacc, nresp;
    bit took;
    bit saw_resp;

    reset = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset resp_valid", {31'h0, resp_valid}, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("post-reset ready", {31'h0, req_ready}, 32'h1);
    check("post-reset busy", {31'h0, busy}, 32'h0);
    check("post-reset resp_valid", {31'h0, resp_valid}, 32'h0);
    check("post-reset rdata", resp_rdata, 32'h0);
    check("post-reset fault", {31'h0, resp_fault}, 32'h0);

    do_op("SW 0x10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1);
    do_op("LW 0x10",  1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2);
    do_op("SB 0x13",  1'b1, 3'b000, 32'h13, 32'h12345680, 32'h0,        1'b0, 1);
    do_op("LB 0x13",  1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 2);
    do_op("LBU 0x13", 1'b0, 3'b100, 32'h13, 32'h0,        32'h00000080, 1'b0, 2);
    do_op("LW after SB", 1'b0, 3'b010, 32'h10, 32'h0,     32'h80ADBEEF, 1'b0, 2);
    do_op("SH 0x12",  1'b1, 3'b001, 32'h12, 32'hABCD8001, 32'h0,        1'b0, 1);
    do_op("LH 0x12",  1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8001, 1'b0, 2);
    do_op("LHU 0x12", 1'b0, 3'b101, 32'h12, 32'h0,        32'h00008001, 1'b0, 2);
    do_op("LH 0x10",  1'b0, 3'b001, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, 2);
    do_op("LB 0x10",  1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0, 2);
    do_op("LBU 0x11", 1'b0, 3'b100, 32'h11, 32'h0,        32'h000000BE, 1'b0, 2);

    do_op("flt LH 0x11",    1'b0, 3'b001, 32'h11,       32'h0,        32'h0, 1'b1, 1);
    do_op("flt SW 0x12",    1'b1, 3'b010, 32'h12,       32'h11111111, 32'h0, 1'b1, 1);
    do_op("flt LW 0x1000",  1'b0, 3'b010, 32'h1000,     32'h0,        32'h0, 1'b1, 1);
    do_op("flt LW alias",   1'b0, 3'b010, 32'h80000010, 32'h0,        32'h0, 1'b1, 1);
    do_op("flt SW alias",   1'b1, 3'b010, 32'h80000010, 32'h22222222, 32'h0, 1'b1, 1);
    do_op("flt load f3=011", 1'b0, 3'b011, 32'h10,      32'h0,        32'h0, 1'b1, 1);
    do_op("flt load f3=110", 1'b0, 3'b110, 32'h10,      32'h0,        32'h0, 1'b1, 1);
    do_op("flt store f3=100", 1'b1, 3'b100, 32'h10,     32'h33333333, 32'h0, 1'b1, 1);
    do_op("LW after faults", 1'b0, 3'b010, 32'h10, 32'h0, 32'h8001BEEF, 1'b0, 2);
    do_op("SW 0xFFC", 1'b1, 3'b010, 32'hFFC, 32'hCAFEF00D, 32'h0,        1'b0, 1);
    do_op("LW 0xFFC", 1'b0, 3'b010, 32'hFFC, 32'h0,        32'hCAFEF00D, 1'b0, 2);

    // Held req_valid with alternating SW/LW; accept on each edge where req_ready is seen.
    nacc = 0; nresp = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = bb_we[0]; req_funct3 = 3'b010;
    req_addr = bb_ad[0]; req_wdata = bb_wd[0];
    for (int t = 0; t < 40 && nresp < 6; t++) begin
      if (resp_valid) begin
        if (nresp < 6) check($sformatf("b2b resp %0d rdata", nresp), resp_rdata, bb_ex[nresp]);
        nresp++;
      end
      if (busy !== !req_ready) check("b2b busy vs ready", {31'h0, busy}, {31'h0, !req_ready});
      took = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (took) begin
        if (nacc < 6) acc_cyc[nacc] = t;
        nacc++;
        if (nacc < 6) begin
          req_we = bb_we[nacc]; req_addr = bb_ad[nacc]; req_wdata = bb_wd[nacc];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b accepts", 32'(nacc), 32'd6);
    check("b2b responses", 32'(nresp), 32'd6);
    for (int i = 0; i < 5; i++) begin
      if (i + 1 < nacc)
        check($sformatf("b2b spacing %0d", i), 32'(acc_cyc[i+1] - acc_cyc[i]),
              bb_we[i] ? 32'd2 : 32'd3);
    end

    // Reset during the READ cycle of a load.
    do_op("SW 0x30", 1'b1, 3'b010, 32'h30, 32'h5A5AA5A5, 32'h0,        1'b0, 1);
    do_op("LW 0x30", 1'b0, 3'b010, 32'h30, 32'h0,        32'h5A5AA5A5, 1'b0, 2);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h30;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("rst mid busy before", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    check("rst mid resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst mid ready", {31'h0, req_ready}, 32'h1);
    check("rst mid rdata", resp_rdata, 32'h0);
    check("rst mid fault", {31'h0, resp_fault}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    saw_resp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    check("rst dropped response", {31'h0, saw_resp}, 32'h0);
    do_op("LW 0x30 after reset", 1'b0, 3'b010, 32'h30, 32'h0, 32'h5A5AA5A5, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory stage that sits directly downstream of the ALU in the RV32I core: it takes the ALU result as the effective address plus the rs2 operand and executes RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) against an internal synchronous-read RAM. It produces a sign- or zero-extended load result for the register-file write-data mux and flags misaligned, out-of-range or illegal accesses. The core holds its PC with `enable` while `busy` is high.

## Interface
- MEM_BYTES, 4096, RAM size in bytes; power of two, at least 4; RAM is MEM_BYTES/4 words of 32 bits.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  decoder/ALU presents a memory operation this cycle.
- req_ready  out  1  high only in IDLE; a request is accepted on a rising edge where req_valid && req_ready && !reset.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  effective address (ALU result).
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  qualified by resp_valid; 1 = access rejected.
- busy  out  1  high in READ and RESP states (= !req_ready).

## Operation
- States: IDLE, READ, RESP. Reset → IDLE.
- Fault check on accept, combinational from the request:
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠00.
  - Out of range: req_addr ≥ MEM_BYTES. All 32 bits are compared; no aliasing.
- Accept with fault: no RAM access, no write. → RESP with resp_fault=1, resp_rdata=0.
- Accept store:
  - Byte-lane write on the accept edge. Word index is addr[log2(MEM_BYTES)-1:2].
  - SB writes lane addr[1:0] with wdata[7:0]; SH writes lanes {addr[1],0}/{addr[1],1} with wdata[15:0]; SW writes all four lanes.
  - Unwritten lanes are unchanged. → RESP with resp_fault=0, resp_rdata=0.
- Accept load:
  - The RAM word read is registered on the accept edge; the address and funct3 are latched. → READ.
- READ:
  - Select byte (lane addr[1:0]) or halfword (lane addr[1]) from the RAM word.
  - Extend: B/H sign-extend, BU/HU zero-extend, W passes through.
  - Register the result into resp_rdata. → RESP.
- RESP: resp_valid=1 for exactly this cycle. → IDLE.
- Requests presented while busy are ignored; the requester must hold them until req_ready.
- resp_rdata and resp_fault hold their value after the pulse until the next response.
- RAM contents are not initialised or cleared by reset.

## Timing
- Reset values: state IDLE, req_ready=1, busy=0, resp_valid=0, resp_rdata=0, resp_fault=0.
- Store or fault accepted at edge N: resp_valid is high in cycle N+1 (one cycle after accept). Next accept at edge N+2 at the earliest.
- Load accepted at edge N: READ in cycle N+1; resp_valid and data valid in cycle N+2. Next accept at edge N+3 at the earliest.
- Store→load to the same address back-to-back returns the newly written data: the write commits at edge N and the read samples at edge N+2 or later.
- Reset asserted mid-operation:
  - Immediate return to IDLE; a pending response is dropped (no resp_valid pulse).
  - A store already committed at its accept edge is not reverted.
- req_valid high during reset is not accepted. The first accept is possible on the first edge after reset deasserts.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 → resp_valid two cycles after accept, rdata=0xDEADBEEF, fault=0; store response one cycle after accept with rdata=0.
- SB 0x80 to 0x13, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LW 0x10 → 0x80ADBEEF (other lanes intact).
- SH 0x8001 to 0x12, then LH 0x12 → 0xFFFF8001; LHU 0x12 → 0x00008001.
- Faults, each giving fault=1, rdata=0 one cycle after accept with memory unchanged:
  - LH at 0x11
  - SW at 0x12
  - LW at MEM_BYTES (0x1000)
  - load with funct3=011
  - store with funct3=100
- Hold req_valid continuously with alternating LW/SW → accepts are spaced 3 and 2 cycles apart, req_ready=0 while busy, and no request is lost or duplicated.
- Assert reset in the READ cycle of a load → no resp_valid pulse, outputs at reset values; a subsequent LW of the same word returns the stored data.
